// File: rtl/hilo_md_unit.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers.
// Each result is computed at its start edge and then held back until a fixed latency expires.
module hilo_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_active
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        res_hi_q, res_hi_d;
  logic [31:0]        res_lo_q, res_lo_d;

  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] rs_s, rt_s, quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic               div_zero, div_ovf;

  // Arithmetic datapath; divide-by-zero and the signed overflow case are forced explicitly
  always_comb begin
    rs_sx    = {{32{rs_val[31]}}, rs_val};
    rt_sx    = {{32{rt_val[31]}}, rt_val};
    prod_s   = rs_sx * rt_sx;
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    rs_s     = rs_val;
    rt_s     = rt_val;
    div_zero = (rt_val == 32'd0);
    div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    quo_s    = 32'sd0;
    rem_s    = 32'sd0;
    quo_u    = 32'd0;
    rem_u    = 32'd0;
    if (!div_zero && !div_ovf) begin
      quo_s = rs_s / rt_s;
      rem_s = rs_s % rt_s;
    end
    if (!div_zero) begin
      quo_u = rs_val / rt_val;
      rem_u = rs_val % rt_val;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0: begin
              res_hi_d = prod_s[63:32];
              res_lo_d = prod_s[31:0];
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            3'd1: begin
              res_hi_d = prod_u[63:32];
              res_lo_d = prod_u[31:0];
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            3'd2: begin
              if (div_zero) begin
                res_hi_d = rs_val;
                res_lo_d = 32'hFFFF_FFFF;
              end else if (div_ovf) begin
                res_hi_d = 32'd0;
                res_lo_d = 32'h8000_0000;
              end else begin
                res_hi_d = rem_s;
                res_lo_d = quo_s;
              end
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            3'd3: begin
              if (div_zero) begin
                res_hi_d = rs_val;
                res_lo_d = 32'hFFFF_FFFF;
              end else begin
                res_hi_d = rem_u;
                res_lo_d = quo_u;
              end
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            3'd4:    hi_d = rs_val;
            3'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Any start arriving here is dropped; the hazard unit is expected to prevent it
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == RUN);
  assign md_active = busy | (start & (md_op <= 3'd3));

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit: a table of single operations with expected HI/LO and busy
// length, followed by hand-written sequences for start-while-busy and reset mid-operation.
module tb_hilo_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_active;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[13];

  hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .md_active (md_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one start pulse across a full clock period, checking md_active while it is high
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    start  = 1'b1;
    md_op  = op;
    rs_val = rs;
    rt_val = rt;
    #1;
    checkOutput("md_active_on_start", {63'd0, md_active}, {63'd0, (op <= 3'd3)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] held_hi, held_lo;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{3'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 10};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[5]  = '{3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'h8000_0000, 0};
    vecs[6]  = '{3'd5, 32'h0000_ABCD, 32'd0,         32'h0000_1234, 32'h0000_ABCD, 0};
    vecs[7]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    vecs[8]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, 5};
    vecs[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[10] = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 10};
    vecs[11] = '{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 10};
    vecs[12] = '{3'd6, 32'h5555_5555, 32'd9,         32'd5,         32'hFFFF_FFFF, 0};

    reset  = 1'b1;
    start  = 1'b0;
    md_op  = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_md_active", {63'd0, md_active}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt);
      waitIdle(cyc);
      checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
      checkOutput($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      checkOutput($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
    end

    // multu with an mtlo pulse in the second busy cycle and operands changed mid-run
    held_hi = hi;
    held_lo = lo;
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start  = 1'b1;
    md_op  = 3'd5;
    rs_val = 32'hDEAD_BEEF;
    rt_val = 32'd1;
    #1;
    checkOutput("busy_md_active", {63'd0, md_active}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("run_hi_held", {32'd0, hi}, {32'd0, held_hi});
    checkOutput("run_lo_held", {32'd0, lo}, {32'd0, held_lo});
    waitIdle(cyc);
    checkOutput("ignored_start_busy_cycles", 64'(cyc + 1), 64'd5);
    checkOutput("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    checkOutput("multu_max_lo", {32'd0, lo}, 64'h0000_0001);
    @(negedge clk);
    checkOutput("idle_after_ignored", {63'd0, busy}, 64'd0);

    // div abandoned by reset in its fourth busy cycle
    applyStimulus(3'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    checkOutput("div_busy_before_reset", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("async_reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("async_reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("post_reset_lo", {32'd0, lo}, 64'd0);
    checkOutput("post_reset_busy", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
